// File: rtl/m20k_req_ctrl.sv
// m20k_req_ctrl: credit-based request/response controller for a synchronous RAM.
// Write acknowledges are enabled by defining M20K_REQ_CTRL_WRACK_EN.
module m20k_req_ctrl #(
   parameter int AW    = 10,
   parameter int DW    = 16,
   parameter int DEPTH = 4
) (
   input  logic          CLK,
   input  logic          RSTN,
   input  logic          REQ_VALID,
   output logic          REQ_READY,
   input  logic          REQ_WE,
   input  logic [AW-1:0] REQ_ADDR,
   input  logic [DW-1:0] REQ_DATA,
   input  logic [DW-1:0] REQ_WEM,
   output logic          RSP_VALID,
   input  logic          RSP_READY,
   output logic [DW-1:0] RSP_DATA,
`ifdef M20K_REQ_CTRL_WRACK_EN
   output logic          RSP_WR,
`endif
   output logic          MEM_CE,
   output logic          MEM_WE,
   output logic [AW-1:0] MEM_A,
   output logic [DW-1:0] MEM_D,
   output logic [DW-1:0] MEM_WEM,
   input  logic [DW-1:0] MEM_Q
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic          acc;
   logic          push;
   logic          pop;
   logic          pend_q, pend_d;
   logic [PW-1:0] wp_q, wp_d;
   logic [PW-1:0] rp_q, rp_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW:0]   used;
   logic [DW-1:0] push_dat;
   logic [DW-1:0] dat_q [DEPTH];
`ifdef M20K_REQ_CTRL_WRACK_EN
   logic          pend_wr_q, pend_wr_d;
   logic          wr_q [DEPTH];
`endif

   // In-flight reads hold a credit, so the FIFO can never overflow.
   assign used      = {1'b0, cnt_q} + {{CW{1'b0}}, pend_q};
   assign REQ_READY = RSTN & (used < (CW+1)'(DEPTH));
   assign acc       = REQ_VALID & REQ_READY;

   assign MEM_CE  = acc;
   assign MEM_WE  = acc & REQ_WE;
   assign MEM_A   = REQ_ADDR;
   assign MEM_D   = REQ_DATA;
   assign MEM_WEM = REQ_WEM;

   assign RSP_VALID = (cnt_q != '0);
   assign RSP_DATA  = RSP_VALID ? dat_q[rp_q] : '0;
   assign pop       = RSP_VALID & RSP_READY;
   assign push      = pend_q;

`ifdef M20K_REQ_CTRL_WRACK_EN
   assign RSP_WR   = RSP_VALID & wr_q[rp_q];
   assign push_dat = pend_wr_q ? '0 : MEM_Q;
`else
   assign push_dat = MEM_Q;
`endif

   always_comb begin
      pend_d = acc & ~REQ_WE;
      wp_d   = wp_q;
      rp_d   = rp_q;
      cnt_d  = cnt_q;
`ifdef M20K_REQ_CTRL_WRACK_EN
      pend_d    = acc;
      pend_wr_d = acc & REQ_WE;
`endif
      if (push) begin
         wp_d = (wp_q == PW'(DEPTH-1)) ? '0 : wp_q + PW'(1);
      end
      if (pop) begin
         rp_d = (rp_q == PW'(DEPTH-1)) ? '0 : rp_q + PW'(1);
      end
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         pend_q <= 1'b0;
         wp_q   <= '0;
         rp_q   <= '0;
         cnt_q  <= '0;
      end else begin
         pend_q <= pend_d;
         wp_q   <= wp_d;
         rp_q   <= rp_d;
         cnt_q  <= cnt_d;
      end
   end

`ifdef M20K_REQ_CTRL_WRACK_EN
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         pend_wr_q <= 1'b0;
      end else begin
         pend_wr_q <= pend_wr_d;
      end
   end
`endif

   // Storage needs no reset: RSP_DATA is masked while the FIFO is empty.
   always_ff @(posedge CLK) begin
      if (push) begin
         dat_q[wp_q] <= push_dat;
`ifdef M20K_REQ_CTRL_WRACK_EN
         wr_q[wp_q]  <= pend_wr_q;
`endif
      end
   end

endmodule

// File: tb/tb_m20k_req_ctrl.sv
// tb_m20k_req_ctrl: random and directed checks of m20k_req_ctrl
// against a transaction-level response model and a RAM model.
module tb_m20k_req_ctrl;

   localparam int AW    = 10;
   localparam int DW    = 16;
   localparam int DEPTH = 4;

   logic          CLK = 1'b0;
   logic          RSTN;
   logic          REQ_VALID, REQ_READY, REQ_WE;
   logic [AW-1:0] REQ_ADDR;
   logic [DW-1:0] REQ_DATA, REQ_WEM;
   logic          RSP_VALID, RSP_READY;
   logic [DW-1:0] RSP_DATA;
   logic          MEM_CE, MEM_WE;
   logic [AW-1:0] MEM_A;
   logic [DW-1:0] MEM_D, MEM_WEM, MEM_Q;
`ifdef M20K_REQ_CTRL_WRACK_EN
   logic          RSP_WR;
`endif

   m20k_req_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .RSTN(RSTN),
      .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
      .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR),
      .REQ_DATA(REQ_DATA), .REQ_WEM(REQ_WEM),
      .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
      .RSP_DATA(RSP_DATA),
`ifdef M20K_REQ_CTRL_WRACK_EN
      .RSP_WR(RSP_WR),
`endif
      .MEM_CE(MEM_CE), .MEM_WE(MEM_WE), .MEM_A(MEM_A),
      .MEM_D(MEM_D), .MEM_WEM(MEM_WEM), .MEM_Q(MEM_Q)
   );

   always #5 CLK = ~CLK;

   // RAM: registered address, unregistered data out, bit-masked writes
   logic [DW-1:0] mem [1<<AW];
   logic [AW-1:0] mem_a_q;
   always @(posedge CLK) begin
      if (MEM_CE) begin
         if (MEM_WE)
            mem[MEM_A] <= (mem[MEM_A] & ~MEM_WEM) | (MEM_D & MEM_WEM);
         mem_a_q <= MEM_A;
      end
   end
   assign MEM_Q = mem[mem_a_q];

   typedef struct {
      logic [DW-1:0] dat;
      int            cyc;
      logic          wr;
   } rsp_t;

   logic [DW-1:0] ref_mem [1<<AW];
   rsp_t          q[$];
   int            cyc = 0;
   int            n_chk = 0;
   int            n_fail = 0;
   int            n_ce = 0;
   int            n_pop = 0;
   int            n_vld = 0;
   int            n_nrdy = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(posedge CLK) cyc <= cyc + 1;

   // Model: every accepted read owns one credit until popped; its entry
   // is visible from two cycles after the accept.
   always @(negedge CLK) begin
      logic exp_rdy, exp_vld, acc;
      if (!RSTN) begin
         q.delete();
         check("rst_ready", 32'(REQ_READY), 32'(0));
         check("rst_valid", 32'(RSP_VALID), 32'(0));
         check("rst_data", 32'(RSP_DATA), 32'(0));
         check("rst_ce", 32'(MEM_CE), 32'(0));
         check("rst_we", 32'(MEM_WE), 32'(0));
      end else begin
         exp_rdy = (q.size() < DEPTH);
         exp_vld = (q.size() != 0) && (q[0].cyc + 2 <= cyc);
         check("req_ready", 32'(REQ_READY), 32'(exp_rdy));
         check("rsp_valid", 32'(RSP_VALID), 32'(exp_vld));
         if (exp_vld) begin
            check("rsp_data", 32'(RSP_DATA), 32'(q[0].dat));
`ifdef M20K_REQ_CTRL_WRACK_EN
            check("rsp_wr", 32'(RSP_WR), 32'(q[0].wr));
`endif
         end
         acc = REQ_VALID && exp_rdy;
         check("mem_ce", 32'(MEM_CE), 32'(acc));
         check("mem_we", 32'(MEM_WE), 32'(acc && REQ_WE));
         if (acc) begin
            check("mem_a", 32'(MEM_A), 32'(REQ_ADDR));
            check("mem_d", 32'(MEM_D), 32'(REQ_DATA));
            check("mem_wem", 32'(MEM_WEM), 32'(REQ_WEM));
         end
         check("full_push", 32'(dut.pend_q && 32'(dut.cnt_q) == DEPTH
               && !(RSP_VALID && RSP_READY)), 32'(0));
         if (MEM_CE) n_ce++;
         if (RSP_VALID) n_vld++;
         if (!REQ_READY) n_nrdy++;
         if (RSP_VALID && RSP_READY) n_pop++;
         if (exp_vld && RSP_READY) void'(q.pop_front());
         if (acc) begin
            if (!REQ_WE) begin
               q.push_back('{dat: ref_mem[REQ_ADDR], cyc: cyc, wr: 1'b0});
            end else begin
               ref_mem[REQ_ADDR] = (ref_mem[REQ_ADDR] & ~REQ_WEM)
                                 | (REQ_DATA & REQ_WEM);
`ifdef M20K_REQ_CTRL_WRACK_EN
               q.push_back('{dat: '0, cyc: cyc, wr: 1'b1});
`endif
            end
         end
      end
   end

   task automatic drv(input logic v, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [DW-1:0] m);
      REQ_VALID = v;
      REQ_WE    = we;
      REQ_ADDR  = a;
      REQ_DATA  = d;
      REQ_WEM   = m;
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic idle();
      drv(1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic wait_vld(input string tag);
      int k;
      k = 0;
      @(negedge CLK);
      while (!RSP_VALID && k < 10) begin
         @(negedge CLK);
         k++;
      end
      if (k >= 10) check(tag, 32'(0), 32'(1));
   endtask

   initial begin
      int c0, p0, v0, r0;
      for (int i = 0; i < (1 << AW); i++) begin
         mem[i]     = '0;
         ref_mem[i] = '0;
      end
      mem_a_q   = '0;
      RSTN      = 1'b0;
      RSP_READY = 1'b0;
      idle();
      step(3);
      RSTN = 1'b1;
      #1;
      check("ready_after_rst", 32'(REQ_READY), 32'(1));

      // write then read back with fixed two-cycle latency
      RSP_READY = 1'b1;
      drv(1'b1, 1'b1, 10'h005, 16'hBEEF, 16'hFFFF);
      step(1);
      drv(1'b1, 1'b0, 10'h005, 16'h0000, 16'h0000);
      step(1);
      idle();
      @(negedge CLK);
      check("lat_n1_valid", 32'(RSP_VALID), 32'(0));
      @(negedge CLK);
      check("lat_n2_valid", 32'(RSP_VALID), 32'(1));
      check("lat_n2_data", 32'(RSP_DATA), 32'(16'hBEEF));
      step(2);

      // masked write merges with existing contents
      drv(1'b1, 1'b1, 10'h005, 16'h1234, 16'h00FF);
      step(1);
      drv(1'b1, 1'b0, 10'h005, 16'h0000, 16'h0000);
      step(1);
      idle();
      wait_vld("mask_timeout");
      check("mask_data", 32'(RSP_DATA), 32'(16'hBE34));
      step(4);

      // consumer stalled: credits cap accepts at DEPTH
      RSP_READY = 1'b0;
      c0 = n_ce;
      for (int i = 0; i < 8; i++) begin
         drv(1'b1, 1'b0, 10'(i), 16'h0000, 16'h0000);
         step(1);
      end
      check("stall_accepts", 32'(n_ce - c0), 32'(DEPTH));
      check("stall_ready", 32'(REQ_READY), 32'(0));
      check("stall_cnt", 32'(dut.cnt_q), 32'(DEPTH));
      idle();
      p0 = n_pop;
      RSP_READY = 1'b1;
      step(8);
      check("stall_drain", 32'(n_pop - p0), 32'(DEPTH));

      // back-to-back reads at full rate
      c0 = n_ce;
      r0 = n_nrdy;
      for (int i = 0; i < 16; i++) begin
         drv(1'b1, 1'b0, 10'(i), 16'h0000, 16'h0000);
         step(1);
      end
      idle();
      check("b2b_accepts", 32'(n_ce - c0), 32'(16));
      check("b2b_ready_drop", 32'(n_nrdy - r0), 32'(0));
      step(4);

      // reset mid-flight with cnt=3, pend=1
      RSP_READY = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drv(1'b1, 1'b0, 10'(i), 16'h0000, 16'h0000);
         step(1);
      end
      idle();
      check("pre_rst_cnt", 32'(dut.cnt_q), 32'(3));
      check("pre_rst_pend", 32'(dut.pend_q), 32'(1));
      RSTN = 1'b0;
      #1;
      check("mid_rst_valid", 32'(RSP_VALID), 32'(0));
      check("mid_rst_ready", 32'(REQ_READY), 32'(0));
      step(2);
      RSTN = 1'b1;
      RSP_READY = 1'b1;
      #1;
      check("post_rst_ready", 32'(REQ_READY), 32'(1));
      v0 = n_vld;
      step(6);
      check("post_rst_no_rsp", 32'(n_vld - v0), 32'(0));
      check("post_rst_ready2", 32'(REQ_READY), 32'(1));

`ifdef M20K_REQ_CTRL_WRACK_EN
      drv(1'b1, 1'b1, 10'h3FF, 16'hA5C3, 16'hFFFF);
      step(1);
      drv(1'b1, 1'b0, 10'h3FF, 16'h0000, 16'h0000);
      step(1);
      idle();
      @(negedge CLK);
      check("ack_wr", 32'(RSP_WR), 32'(1));
      check("ack_data", 32'(RSP_DATA), 32'(0));
      @(negedge CLK);
      check("ack_rd_wr", 32'(RSP_WR), 32'(0));
      check("ack_rd_data", 32'(RSP_DATA), 32'(16'hA5C3));
      step(3);
`endif

      // random traffic, with one reset in the middle
      for (int i = 0; i < 600; i++) begin
         logic [AW-1:0] a;
         logic [DW-1:0] m;
         a = ($urandom_range(0, 9) == 0) ? 10'h3FF : 10'($urandom_range(0, 15));
         m = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'($urandom);
         drv($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
             a, 16'($urandom), m);
         RSP_READY = ($urandom_range(0, 3) != 0);
         if (i == 300) RSTN = 1'b0;
         if (i == 302) RSTN = 1'b1;
         step(1);
      end
      idle();
      RSP_READY = 1'b1;
      step(10);
      check("final_empty", 32'(RSP_VALID), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
